// File: rtl/run_monitor.sv
// run_monitor -- watches the retiring-instruction stream of a processor under test.
// After start it counts cycles and retired instructions until a halt opcode is
// seen or a cycle budget is used up. After a halt it waits a fixed drain time
// and then reports done. A run that uses up the budget reports timed_out.
//
// Ports
//   sysclk      : single clock, everything on the rising edge
//   cpu_reset   : synchronous active-high reset, overrides start
//   start       : begin monitoring from IDLE, or restart from DONE/TIMEOUT
//   op          : opcode of the instruction retiring this cycle
//   op_valid    : op holds a retiring instruction this cycle
//   state       : IDLE=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4
//   done        : halt seen and drain complete (sticky until restart/reset)
//   timed_out   : cycle budget used up without a halt (sticky)
//   cycle_cnt   : cycles since start (saturating)
//   instr_cnt   : valid instructions retired since start, halt included (saturating)
//   halt_cycle  : cycle_cnt value on the edge where the halt was sampled
module run_monitor #(
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] HALT_OP = {OP_W{1'b1}},
  parameter int              DRAIN   = 3,
  parameter int              CNT_W   = 32,
  parameter longint          TIMEOUT = 100000
) (
  input  logic             sysclk,
  input  logic             cpu_reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic             op_valid,
  output logic [2:0]       state,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] halt_cycle
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  // The drain counter holds the number of DRAIN edges still to pass before
  // DONE; it is loaded on the halt edge, so the halt edge itself counts as one.
  localparam logic [7:0]       DRAIN_INIT   = (DRAIN > 0) ? 8'(DRAIN - 1) : 8'd0;

  logic [2:0]       state_reg;
  logic             done_reg;
  logic             timed_out_reg;
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic [CNT_W-1:0] instr_cnt_reg;
  logic [CNT_W-1:0] halt_cycle_reg;
  logic [7:0]       drain_rem_reg;

  logic             halt_seen;
  logic [CNT_W-1:0] cycle_cnt_next;
  logic [CNT_W-1:0] instr_cnt_next;

  // Saturating increments: the counters stick at all-ones instead of wrapping.
  always_comb begin
    halt_seen      = op_valid && (op == HALT_OP);
    cycle_cnt_next = (cycle_cnt_reg == CNT_MAX) ? cycle_cnt_reg : cycle_cnt_reg + 1'b1;
    instr_cnt_next = (instr_cnt_reg == CNT_MAX) ? instr_cnt_reg : instr_cnt_reg + 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state_reg      <= ST_IDLE;
      done_reg       <= 1'b0;
      timed_out_reg  <= 1'b0;
      cycle_cnt_reg  <= '0;
      instr_cnt_reg  <= '0;
      halt_cycle_reg <= '0;
      drain_rem_reg  <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          cycle_cnt_reg <= cycle_cnt_next;
          if (op_valid) begin
            instr_cnt_reg <= instr_cnt_next;
          end
          // A halt beats a coincident timeout, so it is tested first.
          if (halt_seen) begin
            halt_cycle_reg <= cycle_cnt_reg;
            if (DRAIN == 0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg     <= ST_DRAIN;
              drain_rem_reg <= DRAIN_INIT;
            end
          end else if (cycle_cnt_reg == TIMEOUT_LAST) begin
            state_reg     <= ST_TIMEOUT;
            timed_out_reg <= 1'b1;
          end
        end

        // Cycles keep counting while draining; instructions, halts and the
        // timeout budget are no longer looked at.
        ST_DRAIN: begin
          cycle_cnt_reg <= cycle_cnt_next;
          if (drain_rem_reg == 8'd0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            drain_rem_reg <= drain_rem_reg - 8'd1;
          end
        end

        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start) begin
            state_reg      <= ST_RUN;
            done_reg       <= 1'b0;
            timed_out_reg  <= 1'b0;
            cycle_cnt_reg  <= '0;
            instr_cnt_reg  <= '0;
            halt_cycle_reg <= '0;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign state      = state_reg;
  assign done       = done_reg;
  assign timed_out  = timed_out_reg;
  assign cycle_cnt  = cycle_cnt_reg;
  assign instr_cnt  = instr_cnt_reg;
  assign halt_cycle = halt_cycle_reg;

endmodule

// File: tb/tb_run_monitor.sv
// Directed testbench for run_monitor. Three builds share one stimulus:
//   u_dut  : DRAIN=3, TIMEOUT=16 (main build)
//   u_dut0 : DRAIN=0, TIMEOUT=16 (halt goes straight to DONE)
//   u_sat  : CNT_W=3, DRAIN=3, TIMEOUT=7 (small counters to show saturation)
module tb_run_monitor;

  logic        sysclk;
  logic        cpu_reset;
  logic        start;
  logic [5:0]  op;
  logic        op_valid;

  logic [2:0]  state;
  logic        done, timed_out;
  logic [31:0] cycle_cnt, instr_cnt, halt_cycle;

  logic [2:0]  z_state;
  logic        z_done, z_timed_out;
  logic [31:0] z_cycle_cnt, z_instr_cnt, z_halt_cycle;

  logic [2:0]  s_state;
  logic        s_done, s_timed_out;
  logic [2:0]  s_cycle_cnt, s_instr_cnt, s_halt_cycle;

  int checks = 0;
  int errors = 0;

  run_monitor #(.OP_W(6), .HALT_OP(6'h3F), .DRAIN(3), .CNT_W(32), .TIMEOUT(16)) u_dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .start(start), .op(op), .op_valid(op_valid),
    .state(state), .done(done), .timed_out(timed_out),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .halt_cycle(halt_cycle)
  );

  run_monitor #(.OP_W(6), .HALT_OP(6'h3F), .DRAIN(0), .CNT_W(32), .TIMEOUT(16)) u_dut0 (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .start(start), .op(op), .op_valid(op_valid),
    .state(z_state), .done(z_done), .timed_out(z_timed_out),
    .cycle_cnt(z_cycle_cnt), .instr_cnt(z_instr_cnt), .halt_cycle(z_halt_cycle)
  );

  run_monitor #(.OP_W(6), .HALT_OP(6'h3F), .DRAIN(3), .CNT_W(3), .TIMEOUT(7)) u_sat (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .start(start), .op(op), .op_valid(op_valid),
    .state(s_state), .done(s_done), .timed_out(s_timed_out),
    .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt), .halt_cycle(s_halt_cycle)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Advance one rising edge and settle 1 time unit past it before sampling.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    cpu_reset = 1'b1; start = 1'b0; op = 6'h00; op_valid = 1'b0;
    step();
    cpu_reset = 1'b0;
  endtask

  task automatic test_reset();
    cpu_reset = 1'b1; start = 1'b0; op = 6'h00; op_valid = 1'b0;
    step();
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (done !== 1'b0 || timed_out !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%0b to=%0b exp 0/0", done, timed_out); end
    checks++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0 || halt_cycle !== 32'd0) begin errors++; $display("FAIL reset_counters got cyc=%0d ins=%0d hc=%0d exp 0/0/0", cycle_cnt, instr_cnt, halt_cycle); end
    cpu_reset = 1'b0;
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold got=%0d exp=0", state); end
    $display("test_reset: state=%0d cycle_cnt=%0d", state, cycle_cnt);
  endtask

  // Start, 5 valid ops among cycles 0..6, halt at cycle 7, drain 3 edges.
  task automatic test_halt_drain();
    logic [6:0] valid_pat;
    valid_pat = 7'b1011011; // bit i = op_valid on the edge with cycle_cnt=i
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 3'd1 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin errors++; $display("FAIL start_run got st=%0d cyc=%0d ins=%0d exp 1/0/0", state, cycle_cnt, instr_cnt); end
    for (int i = 0; i < 7; i++) begin
      op = 6'(i + 1);
      op_valid = valid_pat[i];
      step();
    end
    checks++; if (cycle_cnt !== 32'd7 || instr_cnt !== 32'd5 || state !== 3'd1) begin errors++; $display("FAIL run_counts got cyc=%0d ins=%0d st=%0d exp 7/5/1", cycle_cnt, instr_cnt, state); end
    op = 6'h3F; op_valid = 1'b1;
    step();
    checks++; if (state !== 3'd2 || halt_cycle !== 32'd7 || instr_cnt !== 32'd6 || cycle_cnt !== 32'd8) begin errors++; $display("FAIL halt_edge got st=%0d hc=%0d ins=%0d cyc=%0d exp 2/7/6/8", state, halt_cycle, instr_cnt, cycle_cnt); end
    // Further halts during drain must be ignored.
    step();
    checks++; if (state !== 3'd2 || done !== 1'b0 || instr_cnt !== 32'd6 || halt_cycle !== 32'd7 || cycle_cnt !== 32'd9) begin errors++; $display("FAIL drain1 got st=%0d dn=%0b ins=%0d hc=%0d cyc=%0d exp 2/0/6/7/9", state, done, instr_cnt, halt_cycle, cycle_cnt); end
    step();
    checks++; if (state !== 3'd2 || done !== 1'b0 || cycle_cnt !== 32'd10) begin errors++; $display("FAIL drain2 got st=%0d dn=%0b cyc=%0d exp 2/0/10", state, done, cycle_cnt); end
    op_valid = 1'b0;
    step();
    checks++; if (state !== 3'd3 || done !== 1'b1 || timed_out !== 1'b0 || cycle_cnt !== 32'd11 || instr_cnt !== 32'd6) begin errors++; $display("FAIL done_edge got st=%0d dn=%0b to=%0b cyc=%0d ins=%0d exp 3/1/0/11/6", state, done, timed_out, cycle_cnt, instr_cnt); end
    op_valid = 1'b1; op = 6'h01;
    step();
    step();
    op_valid = 1'b0;
    checks++; if (state !== 3'd3 || done !== 1'b1 || cycle_cnt !== 32'd11 || instr_cnt !== 32'd6) begin errors++; $display("FAIL done_sticky got st=%0d dn=%0b cyc=%0d ins=%0d exp 3/1/11/6", state, done, cycle_cnt, instr_cnt); end
    $display("test_halt_drain: halt_cycle=%0d instr_cnt=%0d cycle_cnt=%0d", halt_cycle, instr_cnt, cycle_cnt);
  endtask

  // Restart from DONE, then a start pulse during RUN must not clear counters.
  task automatic test_back_to_back();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 3'd1 || done !== 1'b0 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0 || halt_cycle !== 32'd0) begin errors++; $display("FAIL restart got st=%0d dn=%0b cyc=%0d ins=%0d hc=%0d exp 1/0/0/0/0", state, done, cycle_cnt, instr_cnt, halt_cycle); end
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 3'd1 || cycle_cnt !== 32'd3) begin errors++; $display("FAIL start_in_run got st=%0d cyc=%0d exp 1/3", state, cycle_cnt); end
    $display("test_back_to_back: state=%0d cycle_cnt=%0d", state, cycle_cnt);
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    op = 6'h05; op_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++; if (state !== 3'd1 || cycle_cnt !== 32'd15 || timed_out !== 1'b0) begin errors++; $display("FAIL pre_timeout got st=%0d cyc=%0d to=%0b exp 1/15/0", state, cycle_cnt, timed_out); end
    step();
    checks++; if (state !== 3'd4 || timed_out !== 1'b1 || done !== 1'b0 || cycle_cnt !== 32'd16) begin errors++; $display("FAIL timeout_edge got st=%0d to=%0b dn=%0b cyc=%0d exp 4/1/0/16", state, timed_out, done, cycle_cnt); end
    op = 6'h3F; op_valid = 1'b1;
    step();
    step();
    op_valid = 1'b0;
    checks++; if (state !== 3'd4 || timed_out !== 1'b1 || cycle_cnt !== 32'd16 || instr_cnt !== 32'd0) begin errors++; $display("FAIL timeout_sticky got st=%0d to=%0b cyc=%0d ins=%0d exp 4/1/16/0", state, timed_out, cycle_cnt, instr_cnt); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 3'd1 || timed_out !== 1'b0 || cycle_cnt !== 32'd0) begin errors++; $display("FAIL timeout_restart got st=%0d to=%0b cyc=%0d exp 1/0/0", state, timed_out, cycle_cnt); end
    $display("test_timeout: state=%0d timed_out=%0b", state, timed_out);
  endtask

  // Halt opcode without op_valid is ignored; a valid halt on the last budget
  // cycle beats the timeout.
  task automatic test_invalid_halt();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    op = 6'h3F; op_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++; if (state !== 3'd1 || cycle_cnt !== 32'd15 || instr_cnt !== 32'd0) begin errors++; $display("FAIL invalid_halt got st=%0d cyc=%0d ins=%0d exp 1/15/0", state, cycle_cnt, instr_cnt); end
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    checks++; if (state !== 3'd2 || timed_out !== 1'b0 || halt_cycle !== 32'd15 || instr_cnt !== 32'd1) begin errors++; $display("FAIL halt_wins got st=%0d to=%0b hc=%0d ins=%0d exp 2/0/15/1", state, timed_out, halt_cycle, instr_cnt); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (state !== 3'd3 || done !== 1'b1 || timed_out !== 1'b0 || cycle_cnt !== 32'd19) begin errors++; $display("FAIL late_done got st=%0d dn=%0b to=%0b cyc=%0d exp 3/1/0/19", state, done, timed_out, cycle_cnt); end
    $display("test_invalid_halt: state=%0d halt_cycle=%0d", state, halt_cycle);
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    op = 6'h3F; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL enter_drain got st=%0d exp 2", state); end
    cpu_reset = 1'b1; start = 1'b1;
    step();
    checks++; if (state !== 3'd0 || done !== 1'b0 || timed_out !== 1'b0 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0 || halt_cycle !== 32'd0) begin errors++; $display("FAIL reset_drain got st=%0d dn=%0b to=%0b cyc=%0d ins=%0d hc=%0d exp all 0", state, done, timed_out, cycle_cnt, instr_cnt, halt_cycle); end
    cpu_reset = 1'b0;
    step();
    start = 1'b0;
    checks++; if (state !== 3'd1 || cycle_cnt !== 32'd0) begin errors++; $display("FAIL run_after_reset got st=%0d cyc=%0d exp 1/0", state, cycle_cnt); end
    $display("test_reset_mid_drain: state=%0d", state);
  endtask

  task automatic test_drain_zero();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    op = 6'h3F; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    checks++; if (z_state !== 3'd3 || z_done !== 1'b1 || z_halt_cycle !== 32'd2 || z_instr_cnt !== 32'd1 || z_cycle_cnt !== 32'd3) begin errors++; $display("FAIL drain_zero got st=%0d dn=%0b hc=%0d ins=%0d cyc=%0d exp 3/1/2/1/3", z_state, z_done, z_halt_cycle, z_instr_cnt, z_cycle_cnt); end
    step();
    checks++; if (z_state !== 3'd3 || z_cycle_cnt !== 32'd3) begin errors++; $display("FAIL drain_zero_sticky got st=%0d cyc=%0d exp 3/3", z_state, z_cycle_cnt); end
    $display("test_drain_zero: state=%0d done=%0b", z_state, z_done);
  endtask

  // 3-bit counters: halt at cycle 6, three drain edges must stick at 7.
  task automatic test_saturate();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    op_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    op = 6'h3F; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    checks++; if (s_state !== 3'd2 || s_halt_cycle !== 3'd6 || s_cycle_cnt !== 3'd7) begin errors++; $display("FAIL sat_halt got st=%0d hc=%0d cyc=%0d exp 2/6/7", s_state, s_halt_cycle, s_cycle_cnt); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (s_state !== 3'd3 || s_done !== 1'b1 || s_cycle_cnt !== 3'd7) begin errors++; $display("FAIL sat_cycle got st=%0d dn=%0b cyc=%0d exp 3/1/7", s_state, s_done, s_cycle_cnt); end
    $display("test_saturate: cycle_cnt=%0d", s_cycle_cnt);
  endtask

  initial begin
    cpu_reset = 1'b1; start = 1'b0; op = 6'h00; op_valid = 1'b0;
    test_reset();
    test_halt_drain();
    test_back_to_back();
    test_timeout();
    test_invalid_halt();
    test_reset_mid_drain();
    test_drain_zero();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
